// File: rtl/packet_framer_pkg.sv
// Shared types and defaults for the packet framer and its skid buffer.
// Optional build macro: PACKET_FRAMER_STATS_EN (packet / dropped-command counters).
package packet_framer_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_LEN_W  = 16;

    // One framed beat as it travels through the skid buffer.
    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      sop;
        logic                      eop;
    } beat_t;

    // Framing FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Saturating increment for the 32-bit packet counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Saturating increment for the 16-bit dropped-command counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/packet_framer_skid.sv
// Two-entry valid/ready skid buffer. The head register drives the outputs
// directly, so a stalled beat stays stable until it is popped. Entries are
// kept in head/tail shift order: nothing is ever reordered.
module packet_framer_skid
    import packet_framer_pkg::*;
#(
    parameter type beat_type_t = beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  beat_type_t i_beat,
    input  logic       i_pop,
    output beat_type_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    beat_type_t r_head;
    beat_type_t r_tail;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    // A push into a full buffer or a pop from an empty one is ignored.
    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    // Storage and occupancy update; simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_beat;
                    end else begin
                        r_tail <= i_beat;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end else begin
                        r_head <= r_head;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_beat;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_beat;
                    end
                    r_count <= r_count;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/packet_framer.sv
// Packet framer: turns an unframed word stream plus per-packet length
// commands into a framed valid/ready stream with start/end-of-packet marks.
// Optional build macro: PACKET_FRAMER_STATS_EN adds saturating pkt_count
// (eop beats delivered) and drop_count (zero-length commands) outputs.
module packet_framer
    import packet_framer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              len_valid,
    output logic              len_ready,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data,
    output logic              startofpacket,
    output logic              endofpacket
`ifdef PACKET_FRAMER_STATS_EN
    ,
    output logic [31:0]       pkt_count,
    output logic [15:0]       drop_count
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } frame_beat_t;

    localparam logic [LEN_W-1:0] LP_LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LP_LEN_ONE  = LEN_W'(1'b1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic             r_first;

    logic        w_len_ready;
    logic        w_in_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_cmd_take;
    logic        w_cmd_drop;
    logic        w_full;
    logic        w_empty;
    frame_beat_t w_beat;
    frame_beat_t w_head;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake decode; ready signals depend on registered
    // state and buffer occupancy only, never on out_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_len_ready = 1'b0;
        w_in_ready  = 1'b0;
        w_push      = 1'b0;
        w_cmd_take  = 1'b0;
        w_cmd_drop  = 1'b0;
        case (r_state)
            IDLE: begin
                w_len_ready = 1'b1;
                if (len_valid) begin
                    if (len != LP_LEN_ZERO) begin
                        w_cmd_take  = 1'b1;
                        w_state_nxt = BURST;
                    end else begin
                        w_cmd_drop  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BURST: begin
                w_in_ready = !w_full;
                if (in_valid && !w_full) begin
                    w_push = 1'b1;
                    if (r_remaining == LP_LEN_ONE) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = BURST;
                    end
                end else begin
                    w_state_nxt = BURST;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Per-packet word countdown and first-beat flag. The countdown only
    // decrements on a push while in BURST, so it reaches zero exactly on eop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= LP_LEN_ZERO;
            r_first     <= 1'b0;
        end else if (w_cmd_take) begin
            r_remaining <= len;
            r_first     <= 1'b1;
        end else if (w_push) begin
            r_remaining <= r_remaining - LP_LEN_ONE;
            r_first     <= 1'b0;
        end else begin
            r_remaining <= r_remaining;
            r_first     <= r_first;
        end
    end

    assign w_beat.data = in_data;
    assign w_beat.sop  = r_first;
    assign w_beat.eop  = (r_remaining == LP_LEN_ONE);

    packet_framer_skid #(
        .beat_type_t (frame_beat_t)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_beat  (w_beat),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop         = !w_empty && out_ready;
    assign out_valid     = !w_empty;
    assign data          = w_head.data;
    assign startofpacket = w_head.sop;
    assign endofpacket   = w_head.eop;
    assign len_ready     = w_len_ready;
    assign in_ready      = w_in_ready;

`ifdef PACKET_FRAMER_STATS_EN
    logic [31:0] r_pkt_count;
    logic [15:0] r_drop_count;

    // Saturating statistics: packets delivered downstream, empty commands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_count  <= 32'd0;
            r_drop_count <= 16'd0;
        end else begin
            if (w_pop && w_head.eop) begin
                r_pkt_count <= sat_inc32(r_pkt_count);
            end else begin
                r_pkt_count <= r_pkt_count;
            end
            if (w_cmd_drop) begin
                r_drop_count <= sat_inc16(r_drop_count);
            end else begin
                r_drop_count <= r_drop_count;
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;
`endif

endmodule
